// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side stream adapter.
package async_fifo_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_ADDR_WIDTH = 4;

   // Flush handling states of the read adapter
   typedef enum logic {
      ACTIVE,
      DRAIN_DROP
   } flush_state_e;

   // Circular pointer increment that wraps explicitly at depth-1
   function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/async_fifo_rd_stream_buf.sv
// Small circular buffer with push/pop/clear and an occupancy count.
module rd_stream_buf
   import async_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clr_i,
   input  logic                         push_i,
   input  logic [DATA_WIDTH-1:0]        wdata_i,
   input  logic                         pop_i,
   output logic [DATA_WIDTH-1:0]        rdata_o,
   output logic [$clog2(DEPTH+1)-1:0]   level_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;

   // Next pointers and occupancy; clear wins over push/pop
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      if (clr_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = PTR_W'(wrap_inc(32'(wr_ptr_q), DEPTH));
         if (pop_i)  rd_ptr_d = PTR_W'(wrap_inc(32'(rd_ptr_q), DEPTH));
         case ({push_i, pop_i})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage write at the tail; contents need no reset
   always_ff @(posedge clk_i) begin
      if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side adapter: issues FIFO reads against local buffer credit, absorbs
// the one-cycle read latency and presents a valid/ready stream.
module async_fifo_rd_stream
   import async_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned BUF_DEPTH  = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                             rclk,
   input  logic                             rrst,
   input  logic                             rempty,
   input  logic [DATA_WIDTH-1:0]            rdata,
   output logic                             rinc,
   output logic                             m_valid,
   output logic [DATA_WIDTH-1:0]            m_data,
   input  logic                             m_ready,
   input  logic                             flush,
   output logic [CNT_WIDTH-1:0]             words_out,
   output logic [$clog2(BUF_DEPTH+1)-1:0]   level
);

   logic                 inflight_q, inflight_d;
   logic                 drop_q, drop_d;
   logic [CNT_WIDTH-1:0] words_q, words_d;
   flush_state_e         state_q, state_d;
   logic                 flush_clr;
   logic                 credit_ok;
   logic                 push;
   logic                 pop;

   // Credit: words held plus the word in flight must leave room for one more
   assign credit_ok = (32'(level) + 32'(inflight_q)) < BUF_DEPTH;
   assign rinc      = !rempty && !flush && !rrst && credit_ok;
   assign m_valid   = (level != '0);
   assign push      = inflight_q && !drop_q && !flush_clr;
   assign pop       = m_valid && m_ready && !flush_clr;

   // Flush FSM state register
   always_ff @(posedge rclk) begin
      if (rrst) state_q <= ACTIVE;
      else      state_q <= state_d;
   end

   // Flush FSM next state; a flush completes in one cycle so ACTIVE is held
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACTIVE:     state_d = ACTIVE;
         DRAIN_DROP: state_d = ACTIVE;
         default:    state_d = ACTIVE;
      endcase
   end

   // Flush FSM output: when to clear the buffer and discard the arriving word
   always_comb begin
      flush_clr = 1'b0;
      case (state_q)
         ACTIVE:  flush_clr = flush;
         default: flush_clr = 1'b1;
      endcase
   end

   // Next values for in-flight tracking, stale-word drop and the counter
   always_comb begin
      inflight_d = rinc;
      drop_d     = flush_clr && inflight_q;
      words_d    = words_q + CNT_WIDTH'(pop);
   end

   // Control registers
   always_ff @(posedge rclk) begin
      if (rrst) begin
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
         words_q    <= '0;
      end else begin
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         words_q    <= words_d;
      end
   end

   rd_stream_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUF_DEPTH)
   ) u_buf (
      .clk_i   (rclk),
      .rst_i   (rrst),
      .clr_i   (flush_clr),
      .push_i  (push),
      .wdata_i (rdata),
      .pop_i   (pop),
      .rdata_o (m_data),
      .level_o (level)
   );

   assign words_out = words_q;

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Scoreboard bench: two adapter instances (depth 4 and depth 3) fed by an
// emulated FIFO read port; expected words are queued at issue time.
module tb_async_fifo_rd_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void check(input string name, input int ln, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s lane%0d: got 0x%0h, expected 0x%0h", name, ln, act, exp);
      end
   endfunction

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int unsigned D = (g == 0) ? 4 : 3;

      logic                       rrst    = 1'b1;
      logic                       rempty  = 1'b1;
      logic                       m_ready = 1'b0;
      logic                       flush   = 1'b0;
      logic [7:0]                 rdata   = '0;
      logic                       rinc;
      logic                       m_valid;
      logic [7:0]                 m_data;
      logic [15:0]                words_out;
      logic [$clog2(D+1)-1:0]     level;

      byte unsigned src_q[$];
      byte unsigned exp_q[$];
      int           m_inflight = 0;
      logic [15:0]  exp_words  = '0;
      bit           done       = 1'b0;

      async_fifo_rd_stream #(
         .DATA_WIDTH (8),
         .BUF_DEPTH  (D),
         .CNT_WIDTH  (16)
      ) dut (
         .rclk      (clk),
         .rrst      (rrst),
         .rempty    (rempty),
         .rdata     (rdata),
         .rinc      (rinc),
         .m_valid   (m_valid),
         .m_data    (m_data),
         .m_ready   (m_ready),
         .flush     (flush),
         .words_out (words_out),
         .level     (level)
      );

      // FIFO read-port emulation and expected-word issue
      initial begin : fifo_emul
         byte unsigned pend;
         bit has_pend;
         pend = 0;
         has_pend = 1'b0;
         forever begin
            @(negedge clk);
            #3;
            has_pend = 1'b0;
            if (rrst) begin
               exp_q.delete();
               src_q.delete();
               m_inflight = 0;
               exp_words  = '0;
            end else begin
               if (flush) exp_q.delete();
               m_inflight = rinc ? 1 : 0;
               if (rinc) begin
                  if (src_q.size() == 0) begin
                     check("rinc_on_empty", g, src_q.size(), 1);
                  end else begin
                     pend = src_q.pop_front();
                     exp_q.push_back(pend);
                     has_pend = 1'b1;
                  end
               end
            end
            @(posedge clk);
            #1;
            rdata  = has_pend ? pend : 8'h00;
            rempty = (src_q.size() == 0);
         end
      end

      // Monitor: compares DUT outputs against the queued expectation
      initial begin : monitor
         bit           prev_stall;
         logic [7:0]   prev_data;
         int           mlvl;
         byte unsigned e;
         prev_stall = 1'b0;
         prev_data  = '0;
         forever begin
            @(negedge clk);
            #2;
            if (rrst) begin
               check("rinc_in_reset", g, rinc, 0);
               prev_stall = 1'b0;
            end else begin
               mlvl = exp_q.size() - m_inflight;
               check("level", g, level, mlvl);
               check("level_bound", g, int'(level) <= D, 1);
               check("m_valid", g, m_valid, mlvl != 0);
               check("rinc", g, rinc, !rempty && !flush && (mlvl + m_inflight) < D);
               check("words_out", g, words_out, exp_words);
               if (prev_stall && m_valid) check("m_data_hold", g, m_data, prev_data);
               if (m_valid && m_ready && !flush) begin
                  if (exp_q.size() == 0) begin
                     check("pop_without_word", g, exp_q.size(), 1);
                  end else begin
                     e = exp_q.pop_front();
                     check("m_data", g, m_data, e);
                  end
                  exp_words++;
               end
               prev_stall = m_valid && !m_ready && !flush;
               prev_data  = m_data;
            end
         end
      end

      task automatic step(input int n);
         repeat (n) @(negedge clk);
      endtask

      task automatic wait_level(input int target, input string name);
         int t;
         t = 0;
         while (int'(level) != target && t < 12) begin
            @(negedge clk);
            t++;
         end
         check(name, g, level, target);
      endtask

      task automatic drain(input string name);
         int t;
         t = 0;
         flush   = 1'b0;
         m_ready = 1'b1;
         while ((src_q.size() != 0 || level != '0 || m_inflight != 0) && t < 80) begin
            @(negedge clk);
            t++;
         end
         check(name, g, level, 0);
      endtask

      // Stimulus
      initial begin : driver
         int base;
         step(2);
         rrst = 1'b0;
         check("reset_words_out", g, words_out, 0);
         check("reset_m_valid", g, m_valid, 0);

         // single word
         src_q.push_back(8'hA5);
         m_ready = 1'b1;
         step(6);
         check("single_words_out", g, words_out, 1);

         // streaming 0x00..0x0F at one word per cycle
         base = int'(words_out);
         for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
         step(18);
         check("stream_15", g, words_out, base + 15);
         step(1);
         check("stream_16", g, words_out, base + 16);
         drain("stream_drain");

         // backpressure
         base = int'(words_out);
         m_ready = 1'b0;
         for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h30 + i));
         step(D + 4);
         check("bp_level", g, level, D);
         check("bp_rinc", g, rinc, 0);
         check("bp_m_valid", g, m_valid, 1);
         check("bp_head", g, m_data, 8'h30);
         drain("bp_drain");
         check("bp_count", g, words_out, base + 8);

         // flush with level 2 and a word in flight
         base = int'(words_out);
         m_ready = 1'b0;
         for (int i = 0; i < 3; i++) src_q.push_back(8'(8'h60 + i));
         wait_level(2, "flush_setup_level");
         flush = 1'b1;
         step(1);
         flush = 1'b0;
         check("flush_level", g, level, 0);
         check("flush_m_valid", g, m_valid, 0);
         src_q.push_back(8'h5C);
         m_ready = 1'b1;
         step(6);
         check("flush_after_count", g, words_out, base + 1);

         // reset mid-operation with level 3
         m_ready = 1'b0;
         for (int i = 0; i < 3; i++) src_q.push_back(8'(8'h70 + i));
         wait_level(3, "reset_setup_level");
         rrst = 1'b1;
         step(1);
         rrst = 1'b0;
         check("rst_level", g, level, 0);
         check("rst_m_valid", g, m_valid, 0);
         check("rst_words_out", g, words_out, 0);

         // randomized traffic with occasional flushes
         for (int c = 0; c < 300; c++) begin
            if ($urandom_range(2) == 0 && src_q.size() < 8) src_q.push_back(8'($urandom));
            m_ready = ($urandom_range(3) != 0);
            flush   = ($urandom_range(24) == 0);
            step(1);
         end
         drain("random_drain");
         step(2);
         done = 1'b1;
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1);
   end

   initial begin : summary
      wait (lane[0].done && lane[1].done);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
